// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - HI/LO owner with 32-step iterative MULTU/DIVU and MTHI/MTLO writes
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_rdata1,
    input  logic [31:0] ex_rdata2,
    input  logic [1:0]  ex_md_op,
    input  logic        ex_to_hi,
    input  logic        ex_to_lo,
    output logic        md_stall,
    output logic        md_done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        start_mul, start_div, start, move, last_step;
    logic [5:0]  cnt;
    logic [31:0] op_a, op_b;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}
    logic [63:0] acc;
    logic [32:0] mul_sum;
    logic [64:0] div_shl;
    logic [32:0] div_diff;
    logic [63:0] mul_acc, div_acc, step_acc;

    always_comb begin
        start_mul = (state == S_IDLE) && ex_valid && (ex_md_op == 2'b01);
        start_div = (state == S_IDLE) && ex_valid && (ex_md_op == 2'b10);
        start     = start_mul || start_div;
        move      = (state == S_IDLE) && ex_valid && !start && (ex_to_hi || ex_to_lo);
        last_step = (cnt == 6'd31);

        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op_a} : 33'd0);
        mul_acc   = {mul_sum, acc[31:1]};

        // A zero divisor never fails the trial subtract, yielding quotient all-ones and remainder A
        div_shl   = {acc, 1'b0};
        div_diff  = div_shl[64:32] - {1'b0, op_b};
        div_acc   = div_diff[32] ? div_shl[63:0] : {div_diff[31:0], div_shl[31:1], 1'b1};

        step_acc  = (state == S_MUL) ? mul_acc : div_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    state_nxt = S_MUL;
                end else if (start_div) begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            // The finished instruction is still in EX here; never restart from DONE
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        md_stall = ((state == S_IDLE) && start) || (state == S_MUL) || (state == S_DIV);
        md_done  = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 6'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            acc    <= 64'd0;
            hi_out <= 32'd0;
            lo_out <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a <= ex_rdata1;
                        op_b <= ex_rdata2;
                        cnt  <= 6'd0;
                        acc  <= start_mul ? {32'd0, ex_rdata2} : {32'd0, ex_rdata1};
                    end else if (move) begin
                        if (ex_to_hi) begin
                            hi_out <= ex_rdata1;
                        end
                        if (ex_to_lo) begin
                            lo_out <= ex_rdata1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= step_acc;
                    cnt <= cnt + 6'd1;
                    if (last_step) begin
                        hi_out <= step_acc[63:32];
                        lo_out <= step_acc[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - randomized self-checking bench for ex_muldiv against an arithmetic HI/LO model
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_rdata1, ex_rdata2;
    logic [1:0]  ex_md_op;
    logic        ex_to_hi, ex_to_lo;
    logic        md_stall, md_done;
    logic [31:0] hi_out, lo_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m, lo_m;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_rdata1 (ex_rdata1),
        .ex_rdata2 (ex_rdata2),
        .ex_md_op  (ex_md_op),
        .ex_to_hi  (ex_to_hi),
        .ex_to_lo  (ex_to_lo),
        .md_stall  (md_stall),
        .md_done   (md_done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        if (op == 2'b01) return wa * wb;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
    endfunction

    // One non-starting cycle: bubble, move, or reserved op
    task automatic idle_cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                              input logic th, input logic tl);
        @(posedge clk); #1;
        ex_valid = v; ex_md_op = op; ex_rdata1 = a; ex_rdata2 = $urandom;
        ex_to_hi = th; ex_to_lo = tl;
        @(negedge clk);
        check("idle_stall", 64'(md_stall), 64'd0);
        check("idle_done", 64'(md_done), 64'd0);
        check("idle_hilo", {hi_out, lo_out}, {hi_m, lo_m});
        if (v && (op == 2'b00 || op == 2'b11)) begin
            if (th) hi_m = a;
            if (tl) lo_m = a;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] junk_move);
        logic [63:0] res;
        res = ref_result(op, a, b);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_md_op = op; ex_rdata1 = a; ex_rdata2 = b;
        ex_to_hi = junk_move[0]; ex_to_lo = junk_move[1];
        @(negedge clk);
        check("start_stall", 64'(md_stall), 64'd1);
        check("start_done", 64'(md_done), 64'd0);
        check("start_hilo", {hi_out, lo_out}, {hi_m, lo_m});
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("busy_stall", 64'(md_stall), 64'd1);
            check("busy_done", 64'(md_done), 64'd0);
            check("busy_hilo", {hi_out, lo_out}, {hi_m, lo_m});
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("done_stall", 64'(md_stall), 64'd0);
        check("done_pulse", 64'(md_done), 64'd1);
        check(op == 2'b01 ? "mul_result" : "div_result", {hi_out, lo_out}, res);
        {hi_m, lo_m} = res;
    endtask

    task automatic rst_mid(input logic [31:0] a, input logic [31:0] b, input int k);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_md_op = 2'b01; ex_rdata1 = a; ex_rdata2 = b;
        ex_to_hi = 1'b0; ex_to_lo = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(md_stall), 64'd0);
        check("rst_done", 64'(md_done), 64'd0);
        check("rst_hilo", {hi_out, lo_out}, 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        idle_cycle(1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_md_op = 2'b00;
        ex_rdata1 = 32'd0; ex_rdata2 = 32'd0; ex_to_hi = 1'b0; ex_to_lo = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", 64'(md_stall), 64'd0);
        check("reset_done", 64'(md_done), 64'd0);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
        do_op(2'b10, 32'd100, 32'd7, 2'b00);
        do_op(2'b10, 32'h00001234, 32'd0, 2'b00);

        idle_cycle(1'b1, 2'b00, 32'hDEADBEEF, 1'b1, 1'b0);
        idle_cycle(1'b1, 2'b00, 32'h12345678, 1'b0, 1'b1);
        idle_cycle(1'b0, 2'b00, 32'hCAFEF00D, 1'b1, 1'b1);
        idle_cycle(1'b1, 2'b11, 32'h0BADF00D, 1'b1, 1'b1);
        idle_cycle(1'b0, 2'b01, 32'h5, 1'b0, 1'b0);
        do_op(2'b01, 32'd6, 32'd7, 2'b01);

        rst_mid(32'd3, 32'd5, 10);
        do_op(2'b01, 32'd3, 32'd5, 2'b00);

        do_op(2'b01, 32'h00010001, 32'h0000FFFF, 2'b00);
        idle_cycle(1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
        do_op(2'b01, 32'd11, 32'd13, 2'b00);
        do_op(2'b10, 32'd9, 32'd2, 2'b00);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: do_op(2'b01, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
                1: do_op(2'b10, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
                2: idle_cycle(1'b1, 2'b00, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                3: idle_cycle(1'b1, 2'b11, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: idle_cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b1);
            endcase
        end
        idle_cycle(1'b0, 2'b00, 32'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Execute-stage consumer of the ID/EX register's HI/LO-related fields. It owns the architectural HI and LO registers, runs MULTU and DIVU as 32-step iterative operations, and services MTHI/MTLO writes. While an operation is in flight it asserts `md_stall`, which holds IF/ID and ID/EX so that the instruction in EX keeps presenting the same operands.

## Interface
Parameters:
- None. The datapath is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ex_valid`  in  1  the instruction currently in EX is valid (not a bubble).
- `ex_rdata1`  in  32  operand A (rs). Multiplicand / dividend / MTHI/MTLO source.
- `ex_rdata2`  in  32  operand B (rt). Multiplier / divisor.
- `ex_md_op`  in  2  operation select: 00 none, 01 MULTU, 10 DIVU, 11 reserved (treated as none).
- `ex_to_hi`  in  1  MTHI: load HI from `ex_rdata1`.
- `ex_to_lo`  in  1  MTLO: load LO from `ex_rdata1`.
- `md_stall`  out  1  freeze request to the IF/ID and ID/EX registers.
- `md_done`  out  1  one-cycle pulse on the cycle a MULTU/DIVU result becomes visible on `hi_out`/`lo_out`.
- `hi_out`  out  32  registered HI value.
- `lo_out`  out  32  registered LO value.

## Operation
- States:
  - IDLE: waiting for work.
  - MUL: shift-add multiply.
  - DIV: restoring divide.
  - DONE: result handoff.
- A start occurs when the state is IDLE, `ex_valid`=1 and `ex_md_op` is 01 or 10.
  - On the start edge: latch A and B into internal registers, clear the 6-bit step counter, move to MUL or DIV.
- MUL performs one step per cycle, unsigned.
  - If the multiplier LSB is 1, add the multiplicand into the upper 33 bits of the 64-bit accumulator.
  - Then shift the accumulator right by 1.
  - After 32 steps, {HI,LO} = A*B, the full 64-bit unsigned product.
- DIV performs one restoring step per cycle, unsigned.
  - Shift the {remainder, quotient} pair left by 1.
  - Trial-subtract B from the 33-bit remainder. If the result is non-negative, keep the difference and set the quotient LSB.
  - After 32 steps, LO = quotient and HI = remainder.
- Divide by zero takes the full 32 steps. The result is fixed: LO=FFFFFFFF, HI=A.
- The final (32nd) step edge writes HI/LO and moves to DONE. HI/LO keep their old values during every intermediate step.
- DONE: `md_done`=1 and `md_stall`=0, so ID/EX advances on this edge. The next state is unconditionally IDLE.
  - The still-present MULTU/DIVU in EX must not restart from DONE.
- MTHI/MTLO act only in IDLE with `ex_valid`=1 and `ex_md_op` set to none.
  - The write lands on that edge, with no stall.
  - `ex_to_hi` and `ex_to_lo` together write both registers with `ex_rdata1`.
- If a start and `ex_to_hi`/`ex_to_lo` are asserted in the same cycle, the start wins and the move is ignored.
- `ex_valid`=0 suppresses both starts and moves.
- `ex_md_op`=11 behaves as none.

## Timing
- Reset values: state IDLE, `hi_out`=0, `lo_out`=0, `md_stall`=0, `md_done`=0, counter 0, operand and accumulator registers 0.
- `md_stall` is combinational: 1 when (IDLE and start condition) or state is MUL or DIV; otherwise 0.
- `md_done` is registered: 1 exactly when the state is DONE.
- For a start accepted in cycle T:
  - `md_stall`=1 in cycles T..T+32, which is 33 cycles.
  - Steps execute on the edges ending T+1..T+32.
  - `hi_out`/`lo_out` show the new result from T+33 onward.
  - `md_done`=1 in T+33 only.
- Back-to-back ops: the next instruction reaches EX at T+34 with the state in IDLE, and can start immediately.
- `rst` during MUL, DIV or DONE: the next cycle is IDLE with HI/LO=0. The partial result is discarded, with no `md_done` pulse and `md_stall`=0.
- MTHI/MTLO latency: 1 cycle. The new value is on `hi_out`/`lo_out` in the cycle after the write.

## Test plan
- MULTU with A=FFFFFFFF, B=FFFFFFFF started at T -> `md_stall` high T..T+32; at T+33 `hi_out`=FFFFFFFE, `lo_out`=00000001, `md_done`=1.
- DIVU with A=100 and B=7 -> at T+33 `lo_out`=14 and `hi_out`=2. HI/LO keep their prior values through T+32.
- DIVU with A=00001234, B=0 -> `lo_out`=FFFFFFFF, `hi_out`=00001234 after 33 stall cycles.
- MTHI A=DEADBEEF, then MTLO A=12345678, in consecutive cycles -> `hi_out`=DEADBEEF, `lo_out`=12345678, `md_stall` never asserted. Same-cycle start plus `ex_to_hi` -> the move is ignored.
- MULTU 3*5 with `rst` pulsed at step 10 -> IDLE next cycle, HI/LO=0, `md_stall`=0, no `md_done`. A following MULTU 3*5 -> `lo_out`=15, `hi_out`=0.
- MULTU held in EX through DONE -> exactly one `md_done` pulse and no restart. An immediate following DIVU 9/2 -> starts in the next cycle, giving `lo_out`=4, `hi_out`=1.
